// File: rtl/snake_pkg.sv
// Shared types and constants for the multi-snake body tracker.
package snake_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirLeft  = 2'd1,
    DirDown  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  localparam int XWDef   = 8;
  localparam int YWDef   = 7;
  localparam int XMaxDef = 159;
  localparam int YMaxDef = 119;

  // Opposite heading: up<->down, left<->right.
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_lane.sv
// One snake: alive/stopped FSM, heading latch, segment shift register and length counter.
module snake_lane
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 64,
  parameter int X_W      = XWDef,
  parameter int Y_W      = YWDef,
  parameter int X_MAX    = XMaxDef,
  parameter int Y_MAX    = YMaxDef,
  parameter bit WRAP     = 1'b1,
  parameter int INIT_LEN = 5,
  localparam int LenW    = $clog2(MAX_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step,
  input  logic [1:0]                    dir_in,
  input  logic                          grow,
  input  logic                          respawn,
  input  logic [X_W-1:0]                spawn_x,
  input  logic [Y_W-1:0]                spawn_y,
  input  logic [1:0]                    spawn_dir,
  output logic [MAX_LEN-1:0][X_W-1:0]   body_x,
  output logic [MAX_LEN-1:0][Y_W-1:0]   body_y,
  output logic [LenW-1:0]               length,
  output logic [1:0]                    cur_dir,
  output logic                          respawned,
  output logic                          hit_wall
);

  typedef enum logic [0:0] {StAlive, StStopped} state_e;

  state_e                        state_q, state_d;
  dir_e                          dir_q, dir_d;
  logic                          grow_q, grow_d;
  logic [LenW-1:0]               len_q, len_d;
  logic [MAX_LEN-1:0][X_W-1:0]   bx_q, bx_d, sp_x;
  logic [MAX_LEN-1:0][Y_W-1:0]   by_q, by_d, sp_y;
  logic                          respawned_q, respawned_d;
  logic                          hit_wall_q, hit_wall_d;
  logic [X_W-1:0]                head_x;
  logic [Y_W-1:0]                head_y;
  logic                          oob;
  int                            nx, ny;

  // Map an unbounded coordinate into the arena: modulo when wrapping, clamp otherwise.
  function automatic logic [X_W-1:0] fit_x(input int v);
    int r;
    if (WRAP) begin
      r = v % (X_MAX + 1);
      if (r < 0) r = r + X_MAX + 1;
    end else begin
      r = (v < 0) ? 0 : ((v > X_MAX) ? X_MAX : v);
    end
    return r[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] fit_y(input int v);
    int r;
    if (WRAP) begin
      r = v % (Y_MAX + 1);
      if (r < 0) r = r + Y_MAX + 1;
    end else begin
      r = (v < 0) ? 0 : ((v > Y_MAX) ? Y_MAX : v);
    end
    return r[Y_W-1:0];
  endfunction

  // Spawn image: head at spawn point, tail trailing opposite the heading.
  always_comb begin
    sp_x = '0;
    sp_y = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < INIT_LEN) begin
        sp_x[i] = spawn_x;
        sp_y[i] = spawn_y;
        case (dir_e'(spawn_dir))
          DirUp:    sp_y[i] = fit_y(int'(spawn_y) + i);
          DirLeft:  sp_x[i] = fit_x(int'(spawn_x) + i);
          DirDown:  sp_y[i] = fit_y(int'(spawn_y) - i);
          default:  sp_x[i] = fit_x(int'(spawn_x) - i);
        endcase
      end
    end
  end

  always_comb begin
    nx = int'(bx_q[0]);
    ny = int'(by_q[0]);
    case (dir_q)
      DirUp:   ny = ny - 1;
      DirLeft: nx = nx - 1;
      DirDown: ny = ny + 1;
      default: nx = nx + 1;
    endcase
    oob    = (nx < 0) || (nx > X_MAX) || (ny < 0) || (ny > Y_MAX);
    head_x = fit_x(nx);
    head_y = fit_y(ny);
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    grow_d      = grow_q | grow;
    len_d       = len_q;
    bx_d        = bx_q;
    by_d        = by_q;
    respawned_d = 1'b0;
    hit_wall_d  = 1'b0;

    if (dir_e'(dir_in) != reverse_dir(dir_q)) dir_d = dir_e'(dir_in);

    if (respawn) begin
      state_d     = StAlive;
      dir_d       = dir_e'(spawn_dir);
      grow_d      = 1'b0;
      len_d       = LenW'(INIT_LEN);
      bx_d        = sp_x;
      by_d        = sp_y;
      respawned_d = 1'b1;
    end else if (step && state_q == StAlive) begin
      if (oob && !WRAP) begin
        hit_wall_d = 1'b1;
        state_d    = StStopped;
      end else begin
        if (grow_q) begin
          // A grow request arriving on the consuming step stays pending.
          grow_d = grow;
          if (len_q < LenW'(MAX_LEN)) len_d = len_q + 1'b1;
        end
        bx_d[0] = head_x;
        by_d[0] = head_y;
        for (int i = 1; i < MAX_LEN; i++) begin
          bx_d[i] = bx_q[i-1];
          by_d[i] = by_q[i-1];
        end
        for (int i = 0; i < MAX_LEN; i++) begin
          if (i >= int'(len_d)) begin
            bx_d[i] = '0;
            by_d[i] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAlive;
      dir_q       <= dir_e'(spawn_dir);
      grow_q      <= 1'b0;
      len_q       <= LenW'(INIT_LEN);
      bx_q        <= sp_x;
      by_q        <= sp_y;
      respawned_q <= 1'b0;
      hit_wall_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      grow_q      <= grow_d;
      len_q       <= len_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      respawned_q <= respawned_d;
      hit_wall_q  <= hit_wall_d;
    end
  end

  assign body_x    = bx_q;
  assign body_y    = by_q;
  assign length    = len_q;
  assign cur_dir   = dir_q;
  assign respawned = respawned_q;
  assign hit_wall  = hit_wall_q;

endmodule

// File: rtl/snake_body_multi.sv
// Array of independent snake lanes sharing a clock, reset and movement tick.
module snake_body_multi
  import snake_pkg::*;
#(
  parameter int NUM_SNAKES = 2,
  parameter int MAX_LEN    = 64,
  parameter int X_W        = XWDef,
  parameter int Y_W        = YWDef,
  parameter int X_MAX      = XMaxDef,
  parameter int Y_MAX      = YMaxDef,
  parameter bit WRAP       = 1'b1,
  parameter int INIT_LEN   = 5,
  localparam int LenW      = $clog2(MAX_LEN + 1)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          step,
  input  logic [NUM_SNAKES-1:0][1:0]                    dir_in,
  input  logic [NUM_SNAKES-1:0]                         grow,
  input  logic [NUM_SNAKES-1:0]                         respawn,
  input  logic [NUM_SNAKES-1:0][X_W-1:0]                spawn_x,
  input  logic [NUM_SNAKES-1:0][Y_W-1:0]                spawn_y,
  input  logic [NUM_SNAKES-1:0][1:0]                    spawn_dir,
  output logic [NUM_SNAKES-1:0][MAX_LEN-1:0][X_W-1:0]   body_x,
  output logic [NUM_SNAKES-1:0][MAX_LEN-1:0][Y_W-1:0]   body_y,
  output logic [NUM_SNAKES-1:0][LenW-1:0]               length,
  output logic [NUM_SNAKES-1:0][1:0]                    cur_dir,
  output logic [NUM_SNAKES-1:0]                         respawned,
  output logic [NUM_SNAKES-1:0]                         hit_wall
);

  for (genvar g = 0; g < NUM_SNAKES; g++) begin : g_lane
    snake_lane #(
      .MAX_LEN  (MAX_LEN),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .X_MAX    (X_MAX),
      .Y_MAX    (Y_MAX),
      .WRAP     (WRAP),
      .INIT_LEN (INIT_LEN)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .step      (step),
      .dir_in    (dir_in[g]),
      .grow      (grow[g]),
      .respawn   (respawn[g]),
      .spawn_x   (spawn_x[g]),
      .spawn_y   (spawn_y[g]),
      .spawn_dir (spawn_dir[g]),
      .body_x    (body_x[g]),
      .body_y    (body_y[g]),
      .length    (length[g]),
      .cur_dir   (cur_dir[g]),
      .respawned (respawned[g]),
      .hit_wall  (hit_wall[g])
    );
  end

endmodule

// File: tb/tb_snake_body_multi.sv
// Directed bench for snake_body_multi: one toroidal and one walled instance share stimulus.
module tb_snake_body_multi;

  logic                  clk = 1'b0;
  logic                  reset, step;
  logic [1:0][1:0]       dir_in, spawn_dir;
  logic [1:0]            grow, respawn;
  logic [1:0][7:0]       spawn_x;
  logic [1:0][6:0]       spawn_y;

  logic [1:0][63:0][7:0] bx, wbx;
  logic [1:0][63:0][6:0] by, wby;
  logic [1:0][6:0]       len, wlen;
  logic [1:0][1:0]       cdir, wcdir;
  logic [1:0]            resp, wresp, hit, whit;

  int n_pass  = 0;
  int n_total = 0;

  snake_body_multi #(.WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .step(step), .dir_in(dir_in), .grow(grow), .respawn(respawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir), .body_x(bx), .body_y(by),
    .length(len), .cur_dir(cdir), .respawned(resp), .hit_wall(hit)
  );

  snake_body_multi #(.WRAP(1'b0)) dut_w (
    .clk(clk), .reset(reset), .step(step), .dir_in(dir_in), .grow(grow), .respawn(respawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir), .body_x(wbx), .body_y(wby),
    .length(wlen), .cur_dir(wcdir), .respawned(wresp), .hit_wall(whit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; step = 1'b1; grow = 2'b11; respawn = 2'b11;
    spawn_x[0] = 8'd20;  spawn_y[0] = 7'd15; spawn_dir[0] = 2'd3;
    spawn_x[1] = 8'd100; spawn_y[1] = 7'd50; spawn_dir[1] = 2'd0;
    dir_in[0] = 2'd3; dir_in[1] = 2'd0;
    tick(); tick();
    reset = 1'b0; step = 1'b0; grow = 2'b00; respawn = 2'b00;
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (bx[0][i] !== 8'(20 - i) || by[0][i] !== 7'd15) bad++;
    n_total++; if (bad !== 0) $display("FAIL reset_body0: %0d bad head slots, want 0", bad);
    else n_pass++;
    bad = 0;
    for (int i = 5; i < 64; i++)
      if (bx[0][i] !== 8'd0 || by[0][i] !== 7'd0 || bx[1][i] !== 8'd0) bad++;
    n_total++; if (bad !== 0) $display("FAIL reset_tail_zero: %0d nonzero slots, want 0", bad);
    else n_pass++;
    n_total++; if (len[0] !== 7'd5) $display("FAIL reset_len: got %0d want 5", len[0]);
    else n_pass++;
    n_total++; if (resp !== 2'b00 || hit !== 2'b00)
      $display("FAIL reset_pulses: resp %b hit %b want 00 00", resp, hit);
    else n_pass++;
    n_total++; if (cdir[0] !== 2'd3) $display("FAIL reset_dir: got %0d want 3", cdir[0]);
    else n_pass++;
    n_total++; if (bx[1][4] !== 8'd100 || by[1][4] !== 7'd54)
      $display("FAIL reset_body1_tail: got (%0d,%0d) want (100,54)", bx[1][4], by[1][4]);
    else n_pass++;
    // Grow asserted during reset must not have been latched.
    step = 1'b1; tick(); step = 1'b0;
    n_total++; if (len[0] !== 7'd5 || bx[0][0] !== 8'd21)
      $display("FAIL reset_wins: len %0d head %0d want 5 21", len[0], bx[0][0]);
    else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reversal();
    dir_in[0] = 2'd1; tick();
    n_total++; if (cdir[0] !== 2'd3) $display("FAIL rev_ignored: got %0d want 3", cdir[0]);
    else n_pass++;
    step = 1'b1; tick(); step = 1'b0;
    n_total++; if (bx[0][0] !== 8'd21 || by[0][0] !== 7'd15)
      $display("FAIL rev_step_head: got (%0d,%0d) want (21,15)", bx[0][0], by[0][0]);
    else n_pass++;
    n_total++; if (bx[0][1] !== 8'd20 || bx[0][4] !== 8'd17 || bx[0][5] !== 8'd0)
      $display("FAIL rev_step_shift: got %0d %0d %0d want 20 17 0", bx[0][1], bx[0][4], bx[0][5]);
    else n_pass++;
    dir_in[0] = 2'd0; tick();
    n_total++; if (cdir[0] !== 2'd0) $display("FAIL turn_up_dir: got %0d want 0", cdir[0]);
    else n_pass++;
    step = 1'b1; tick(); step = 1'b0;
    n_total++; if (bx[0][0] !== 8'd21 || by[0][0] !== 7'd14 || by[0][1] !== 7'd15)
      $display("FAIL turn_up_head: got (%0d,%0d) want (21,14)", bx[0][0], by[0][0]);
    else n_pass++;
    n_total++; if (bx[1][0] !== 8'd100 || by[1][0] !== 7'd48)
      $display("FAIL snake1_moves: got (%0d,%0d) want (100,48)", bx[1][0], by[1][0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    dir_in[0] = 2'd3;
    spawn_x[0] = 8'd159; spawn_y[0] = 7'd10; spawn_dir[0] = 2'd3;
    respawn = 2'b01; tick(); respawn = 2'b00;
    n_total++; if (resp[0] !== 1'b1 || wresp[0] !== 1'b1 || bx[0][4] !== 8'd155)
      $display("FAIL wrap_spawn: resp %b/%b tail %0d want 1/1 155", resp[0], wresp[0], bx[0][4]);
    else n_pass++;
    step = 1'b1; tick(); step = 1'b0;
    n_total++; if (bx[0][0] !== 8'd0 || by[0][0] !== 7'd10 || bx[0][1] !== 8'd159)
      $display("FAIL wrap_x: head %0d next %0d want 0 159", bx[0][0], bx[0][1]);
    else n_pass++;
    n_total++; if (wbx[0][0] !== 8'd159 || wbx[0][4] !== 8'd155 || whit[0] !== 1'b1)
      $display("FAIL wall_hit: head %0d tail %0d hit %b want 159 155 1", wbx[0][0], wbx[0][4],
               whit[0]);
    else n_pass++;
    tick();
    n_total++; if (whit[0] !== 1'b0) $display("FAIL wall_pulse: got %b want 0", whit[0]);
    else n_pass++;
    dir_in[0] = 2'd2; step = 1'b1; tick(); step = 1'b0;
    n_total++; if (wbx[0][0] !== 8'd159 || wby[0][0] !== 7'd10 || wlen[0] !== 7'd5)
      $display("FAIL stopped_ignores_step: head (%0d,%0d) len %0d want (159,10) 5",
               wbx[0][0], wby[0][0], wlen[0]);
    else n_pass++;
    n_total++; if (wcdir[0] !== 2'd2) $display("FAIL stopped_dir: got %0d want 2", wcdir[0]);
    else n_pass++;
    dir_in[0] = 2'd3; spawn_x[0] = 8'd150;
    respawn = 2'b01; tick(); respawn = 2'b00;
    step = 1'b1; tick(); step = 1'b0;
    n_total++; if (wbx[0][0] !== 8'd151) $display("FAIL wall_recover: got %0d want 151", wbx[0][0]);
    else n_pass++;
  endtask

  task automatic test_spawn_edge();
    spawn_x[0] = 8'd2; spawn_y[0] = 7'd10; spawn_dir[0] = 2'd3;
    respawn = 2'b01; tick(); respawn = 2'b00;
    n_total++; if (bx[0][2] !== 8'd0 || bx[0][3] !== 8'd159 || bx[0][4] !== 8'd158)
      $display("FAIL spawn_wrap: got %0d %0d %0d want 0 159 158", bx[0][2], bx[0][3], bx[0][4]);
    else n_pass++;
    n_total++; if (wbx[0][1] !== 8'd1 || wbx[0][3] !== 8'd0 || wbx[0][4] !== 8'd0)
      $display("FAIL spawn_clamp: got %0d %0d %0d want 1 0 0", wbx[0][1], wbx[0][3], wbx[0][4]);
    else n_pass++;
  endtask

  task automatic test_grow();
    spawn_x[0] = 8'd20; spawn_y[0] = 7'd15; spawn_dir[0] = 2'd3; dir_in[0] = 2'd3;
    respawn = 2'b01; tick(); respawn = 2'b00;
    grow[0] = 1'b1; tick(); grow[0] = 1'b0; tick();
    grow[0] = 1'b1; tick(); tick(); grow[0] = 1'b0;
    n_total++; if (len[0] !== 7'd5) $display("FAIL grow_pending: got %0d want 5", len[0]);
    else n_pass++;
    step = 1'b1; tick(); step = 1'b0;
    n_total++; if (len[0] !== 7'd6 || bx[0][0] !== 8'd21 || bx[0][5] !== 8'd16)
      $display("FAIL grow_once: len %0d head %0d tail %0d want 6 21 16", len[0], bx[0][0],
               bx[0][5]);
    else n_pass++;
    step = 1'b1; tick(); step = 1'b0;
    n_total++; if (len[0] !== 7'd6 || bx[0][5] !== 8'd17 || bx[0][6] !== 8'd0)
      $display("FAIL grow_consumed: len %0d tail %0d next %0d want 6 17 0", len[0], bx[0][5],
               bx[0][6]);
    else n_pass++;
    for (int k = 0; k < 70; k++) begin
      grow[0] = 1'b1; tick(); grow[0] = 1'b0;
      step = 1'b1; tick(); step = 1'b0;
    end
    n_total++; if (len[0] !== 7'd64) $display("FAIL grow_saturate: got %0d want 64", len[0]);
    else n_pass++;
    n_total++; if (bx[0][0] !== 8'd92 || bx[0][63] !== 8'd29 || by[0][63] !== 7'd15)
      $display("FAIL full_body: head %0d last (%0d,%0d) want 92 (29,15)", bx[0][0], bx[0][63],
               by[0][63]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    spawn_x[0] = 8'd20; spawn_y[0] = 7'd15; spawn_dir[0] = 2'd3; dir_in[0] = 2'd3;
    respawn = 2'b01; tick();
    spawn_x[1] = 8'd100; spawn_y[1] = 7'd50; spawn_dir[1] = 2'd0; dir_in[1] = 2'd0;
    respawn = 2'b10; step = 1'b1; tick(); respawn = 2'b00; step = 1'b0;
    n_total++; if (bx[0][0] !== 8'd21 || bx[0][1] !== 8'd20)
      $display("FAIL b2b_snake0_step: head %0d next %0d want 21 20", bx[0][0], bx[0][1]);
    else n_pass++;
    n_total++; if (bx[1][0] !== 8'd100 || by[1][0] !== 7'd50 || by[1][1] !== 7'd51 ||
                   len[1] !== 7'd5)
      $display("FAIL b2b_snake1_spawn: head (%0d,%0d) len %0d want (100,50) 5", bx[1][0],
               by[1][0], len[1]);
    else n_pass++;
    n_total++; if (resp !== 2'b10) $display("FAIL b2b_respawned: got %b want 10", resp);
    else n_pass++;
    tick();
    n_total++; if (resp !== 2'b00) $display("FAIL b2b_pulse_end: got %b want 00", resp);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; grow = '0; respawn = '0;
    dir_in = '0; spawn_x = '0; spawn_y = '0; spawn_dir = '0;
    test_reset();
    test_reversal();
    test_wrap();
    test_spawn_edge();
    test_grow();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snake_body_multi.md
SNAKE_BODY_MULTI -- requirements
Module: snake_body_multi

Interface
REQ-001 SHALL have parameter NUM_SNAKES, default 2: number of independent snakes.
REQ-002 SHALL have parameter MAX_LEN, default 64: segment slots per snake.
REQ-003 SHALL have parameters X_W=8, Y_W=7: coordinate widths.
REQ-004 SHALL have parameters X_MAX=159, Y_MAX=119: largest legal coordinate.
REQ-005 SHALL have parameter WRAP, default 1: 1 = toroidal arena, 0 = walls.
REQ-006 SHALL have parameter INIT_LEN, default 5: length after spawn; 1 <= INIT_LEN <= MAX_LEN.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 step  input  1  movement tick shared by all snakes.
REQ-010 dir_in  input  [NUM_SNAKES][2]  requested direction: 0 up, 1 left, 2 down, 3 right.
REQ-011 grow  input  [NUM_SNAKES]  add one segment at the next step.
REQ-012 respawn  input  [NUM_SNAKES]  reload that snake at its spawn point.
REQ-013 spawn_x, spawn_y, spawn_dir  input  [NUM_SNAKES][X_W / Y_W / 2]  spawn head and heading.
REQ-014 body_x, body_y  output  [NUM_SNAKES][MAX_LEN][X_W / Y_W]  segment coordinates; index 0 is the head.
REQ-015 length  output  [NUM_SNAKES][$clog2(MAX_LEN+1)]  live segment count.
REQ-016 cur_dir  output  [NUM_SNAKES][2]  latched legal heading.
REQ-017 respawned, hit_wall  output  [NUM_SNAKES]  one-cycle pulses.

Function
REQ-018 Each snake SHALL have FSM states ALIVE and STOPPED; reset or respawn -> ALIVE; hit_wall -> STOPPED.
REQ-019 cur_dir SHALL update every cycle to dir_in unless dir_in is the reverse of cur_dir ((dir_in ^ cur_dir) == 2); reversals are ignored.
REQ-020 grow SHALL set a sticky per-snake pending flag, cleared by the step that consumes it.
REQ-021 On step in ALIVE, segments SHALL shift (i <= i-1 for 1..MAX_LEN-1) and the head SHALL move one cell along the cur_dir value in effect before that edge.
REQ-022 If pending grow and length < MAX_LEN at a step, length SHALL increment; at MAX_LEN, length SHALL saturate and the flag SHALL clear.
REQ-023 Slots with index >= length SHALL read 0 after every step and every spawn.
REQ-024 WRAP=1: x past X_MAX -> 0, x below 0 -> X_MAX; same for y with Y_MAX.
REQ-025 WRAP=0: a step that would leave the arena SHALL leave the body unchanged, pulse hit_wall for one cycle, and enter STOPPED.
REQ-026 In STOPPED, step SHALL have no effect; dir_in and grow SHALL still be latched.
REQ-027 On respawn, regardless of step: body[i] = spawn head displaced i cells opposite spawn_dir (wrap/clamp per WRAP, i < INIT_LEN); length = INIT_LEN; cur_dir = spawn_dir; grow flag cleared; respawned pulses the next cycle.
REQ-028 Respawn SHALL take priority over a simultaneous step for that snake only; other snakes SHALL step normally.
REQ-029 Snakes SHALL be fully independent; no collision detection in this block.
REQ-030 All outputs SHALL be registered; body updates SHALL be visible one cycle after the step edge.

Reset
REQ-031 Reset SHALL perform a spawn for every snake (REQ-027 values), with respawned = 0 and hit_wall = 0.
REQ-032 Reset asserted alongside step, grow or respawn SHALL win; none of them SHALL take effect.

Structure
REQ-033 A shared package snake_pkg SHALL hold the direction enum (UP, LEFT, DOWN, RIGHT), the reverse-direction function, and the default arena constants.
REQ-034 A sub-module snake_lane SHALL implement one snake (FSM, direction latch, shift register, length counter); the top SHALL instantiate NUM_SNAKES lanes via generate.

Verification
REQ-035 Reset with spawn (20,15) heading right, INIT_LEN 5 -> body x 20,19,18,17,16, y 15, length 5, slots 5..63 = 0.
REQ-036 cur_dir right, dir_in left, then step -> head x 21 (reversal ignored); then dir_in up, step -> head (21,14).
REQ-037 WRAP=1, head (159,y) heading right, step -> head x 0; WRAP=0, same setup -> body unchanged, hit_wall pulse, later steps ignored until respawn.
REQ-038 grow pulsed 3 times between two steps -> length +1 only; 70 grow/step pairs from 5 -> length saturates at 64.
REQ-039 respawn[1] and step in the same cycle -> snake 1 respawns with respawned[1] pulsing next cycle; snake 0 advances one cell.
